spi_txn_arbiter: RTL and testbench

Shares the single SPI master pins (SS, SCLK, MOSI, MISO) between two on-chip requesters: port 0 (card-bus register path driven by host IORD/IOWR accesses) and port 1 (autonomous peripheral status poller that feeds INT). Grants one requester at a time for a whole multi-byte transaction with SS held low, and shifts bytes in SPI mode 0, MSB first. Sits between the card-bus decode logic and the SPI pins in `top`.

---
 rtl/spi_txn_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Two-port SPI master arbiter: grants one requester per multi-byte transaction
// with SS held low, shifting bytes in SPI mode 0, MSB first.
module spi_txn_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_26,
  input  logic       RESET_n,
  input  logic       req_0,
  input  logic       req_1,
  output logic       gnt_0,
  output logic       gnt_1,
  input  logic [7:0] tx_data_0,
  input  logic [7:0] tx_data_1,
  input  logic       tx_last_0,
  input  logic       tx_last_1,
  input  logic       tx_valid_0,
  input  logic       tx_valid_1,
  output logic       tx_ready_0,
  output logic       tx_ready_1,
  output logic [7:0] rx_data,
  output logic       rx_valid_0,
  output logic       rx_valid_1,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, HOLD, SHIFT, RELEASE} state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [8:0] REL_MAX = 9'(2 * CLK_DIV - 1);

  state_t     state, state_next;
  logic       owner, owner_next;
  logic       last_gnt, last_gnt_next;
  logic       tx_last_q, tx_last_next;
  logic [7:0] div_cnt, div_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [8:0] rel_cnt, rel_cnt_next;
  logic       gnt_0_next, gnt_1_next, ss_next, sclk_next, mosi_next;
  logic       rx_valid_0_next, rx_valid_1_next;
  logic [7:0] rx_data_next;
  logic [7:0] tx_shift, tx_shift_next, rx_shift, rx_shift_next;

  logic       req_g, valid_g, last_g, accept, pick;
  logic [7:0] data_g;

  assign req_g      = owner ? req_1 : req_0;
  assign valid_g    = owner ? tx_valid_1 : tx_valid_0;
  assign last_g     = owner ? tx_last_1 : tx_last_0;
  assign data_g     = owner ? tx_data_1 : tx_data_0;
  assign tx_ready_0 = (state == HOLD) && !owner;
  assign tx_ready_1 = (state == HOLD) && owner;
  assign accept     = (state == HOLD) && valid_g;
  assign busy       = (state != IDLE);
  // On a tie the port that did not own the previous transaction wins.
  assign pick       = (req_0 && req_1) ? !last_gnt : !req_0;

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_gnt_next   = last_gnt;
    tx_last_next    = tx_last_q;
    div_cnt_next    = div_cnt;
    bit_cnt_next    = bit_cnt;
    rel_cnt_next    = rel_cnt;
    gnt_0_next      = gnt_0;
    gnt_1_next      = gnt_1;
    ss_next         = SS;
    sclk_next       = SCLK;
    mosi_next       = MOSI;
    rx_valid_0_next = 1'b0;
    rx_valid_1_next = 1'b0;
    rx_data_next    = rx_data;
    tx_shift_next   = tx_shift;
    rx_shift_next   = rx_shift;
    case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          owner_next = pick;
          gnt_0_next = !pick;
          gnt_1_next = pick;
          ss_next    = 1'b0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          tx_shift_next = {data_g[6:0], 1'b0};
          mosi_next     = data_g[7];
          tx_last_next  = last_g;
          div_cnt_next  = 8'd0;
          bit_cnt_next  = 3'd0;
          sclk_next     = 1'b0;
          state_next    = SHIFT;
        end else if (!req_g) begin
          gnt_0_next   = 1'b0;
          gnt_1_next   = 1'b0;
          ss_next      = 1'b1;
          rel_cnt_next = 9'd0;
          state_next   = RELEASE;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_MAX) begin
          div_cnt_next = 8'd0;
          if (!SCLK) begin
            sclk_next     = 1'b1;
            rx_shift_next = {rx_shift[6:0], MISO};
          end else begin
            sclk_next = 1'b0;
            if (bit_cnt == 3'd7) begin
              rx_data_next    = rx_shift;
              rx_valid_0_next = !owner;
              rx_valid_1_next = owner;
              if (tx_last_q || !req_g) begin
                gnt_0_next   = 1'b0;
                gnt_1_next   = 1'b0;
                ss_next      = 1'b1;
                rel_cnt_next = 9'd0;
                state_next   = RELEASE;
              end else begin
                state_next = HOLD;
              end
            end else begin
              bit_cnt_next  = bit_cnt + 3'd1;
              mosi_next     = tx_shift[7];
              tx_shift_next = {tx_shift[6:0], 1'b0};
            end
          end
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      RELEASE: begin
        if (rel_cnt == REL_MAX) begin
          last_gnt_next = owner;
          state_next    = IDLE;
        end else begin
          rel_cnt_next = rel_cnt + 9'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_26 or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_gnt   <= 1'b1;
      tx_last_q  <= 1'b0;
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      rel_cnt    <= 9'd0;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      SS         <= 1'b1;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      rx_valid_0 <= 1'b0;
      rx_valid_1 <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_gnt   <= last_gnt_next;
      tx_last_q  <= tx_last_next;
      div_cnt    <= div_cnt_next;
      bit_cnt    <= bit_cnt_next;
      rel_cnt    <= rel_cnt_next;
      gnt_0      <= gnt_0_next;
      gnt_1      <= gnt_1_next;
      SS         <= ss_next;
      SCLK       <= sclk_next;
      MOSI       <= mosi_next;
      rx_valid_0 <= rx_valid_0_next;
      rx_valid_1 <= rx_valid_1_next;
      rx_data    <= rx_data_next;
    end
  end

  // Shift registers carry pure data and are always overwritten before use.
  always_ff @(posedge clk_26) begin
    tx_shift <= tx_shift_next;
    rx_shift <= rx_shift_next;
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: single-byte vector table plus
// multi-byte, round-robin, abort, mid-byte drop and reset sequences.
module tb_spi_txn_arbiter;

  localparam int CD = 2;

  logic       clk_26 = 1'b0;
  logic       RESET_n;
  logic       req_0, req_1, gnt_0, gnt_1;
  logic [7:0] tx_data_0, tx_data_1;
  logic       tx_last_0, tx_last_1, tx_valid_0, tx_valid_1, tx_ready_0, tx_ready_1;
  logic [7:0] rx_data;
  logic       rx_valid_0, rx_valid_1, SS, SCLK, MOSI, MISO, busy;
  logic       miso_loop, miso_tie;

  assign MISO = miso_loop ? MOSI : miso_tie;

  spi_txn_arbiter #(.CLK_DIV(CD)) dut (
    .clk_26(clk_26), .RESET_n(RESET_n),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .tx_data_0(tx_data_0), .tx_data_1(tx_data_1),
    .tx_last_0(tx_last_0), .tx_last_1(tx_last_1),
    .tx_valid_0(tx_valid_0), .tx_valid_1(tx_valid_1),
    .tx_ready_0(tx_ready_0), .tx_ready_1(tx_ready_1),
    .rx_data(rx_data), .rx_valid_0(rx_valid_0), .rx_valid_1(rx_valid_1),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .busy(busy)
  );

  always #5 clk_26 = ~clk_26;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_26) cyc <= cyc + 1;

  // Bus observers sampled on the falling edge.
  int rises = 0, rv0 = 0, rv1 = 0, both_gnt = 0, xready = 0, ss_gnt_err = 0;
  int phase_err = 0, hi_run = 0;
  bit phase_en = 1'b1, prev_sclk = 1'b0, prev_g0 = 1'b0, prev_g1 = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  int gq[$];

  always @(negedge clk_26) begin
    if (gnt_0 && gnt_1) both_gnt++;
    if (SS !== !(gnt_0 || gnt_1)) ss_gnt_err++;
    if ((gnt_0 && tx_ready_1) || (gnt_1 && tx_ready_0)) xready++;
    if (rx_valid_0) rv0++;
    if (rx_valid_1) rv1++;
    if (SCLK && !prev_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], MOSI};
    end
    prev_sclk = SCLK;
    if (gnt_0 && !prev_g0) gq.push_back(0);
    if (gnt_1 && !prev_g1) gq.push_back(1);
    prev_g0 = gnt_0;
    prev_g1 = gnt_1;
    if (!phase_en) hi_run = 0;
    else if (SCLK) hi_run++;
    else begin
      if (hi_run != 0 && hi_run != CD) phase_err++;
      hi_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit p, input bit v);
    if (p) req_1 = v; else req_0 = v;
  endtask

  task automatic set_tx(input bit p, input logic [7:0] d, input bit l, input bit v);
    if (p) begin tx_data_1 = d; tx_last_1 = l; tx_valid_1 = v; end
    else   begin tx_data_0 = d; tx_last_0 = l; tx_valid_0 = v; end
  endtask

  task automatic wait_gnt(input bit p);
    int t = 0;
    while (!(p ? gnt_1 : gnt_0) && t < 20) begin @(negedge clk_26); t++; end
    chk("grant_wait", p ? gnt_1 : gnt_0, 1);
  endtask

  task automatic wait_ready(input bit p, input int lim);
    int t = 0;
    while (!(p ? tx_ready_1 : tx_ready_0) && t < lim) begin @(negedge clk_26); t++; end
    chk("ready_wait", p ? tx_ready_1 : tx_ready_0, 1);
  endtask

  task automatic wait_rx(input bit p);
    int t = 0;
    while (!(p ? rx_valid_1 : rx_valid_0) && t < 40*CD) begin @(negedge clk_26); t++; end
    chk("rx_wait", p ? rx_valid_1 : rx_valid_0, 1);
  endtask

  int         acc_e[3], rxv_e[3];
  logic [7:0] rxd[3];
  int         ss_break;

  // Full transaction of n bytes (byte i in bytes[8i+:8]); returns at the
  // falling edge where the last rx_valid is seen.
  task automatic run_txn(input bit p, input int n, input logic [23:0] bytes);
    int t;
    bit got;
    ss_break = 0;
    set_req(p, 1'b1);
    wait_gnt(p);
    set_tx(p, bytes[7:0], n == 1, 1'b1);
    for (int i = 0; i < n; i++) begin
      wait_ready(p, 20);
      acc_e[i] = cyc + 1;
      @(negedge clk_26);
      if (SS) ss_break++;
      if (i == n-1) set_tx(p, 8'h00, 1'b0, 1'b0);
      else set_tx(p, bytes[8*(i+1) +: 8], (i+1 == n-1), 1'b1);
      got = 1'b0;
      t = 0;
      while (!got && t < 40*CD) begin
        @(negedge clk_26);
        t++;
        if (p ? rx_valid_1 : rx_valid_0) got = 1'b1;
        else if (SS) ss_break++;
      end
      chk("rx_wait", got, 1);
      rxv_e[i] = cyc;
      rxd[i]   = rx_data;
      if (i < n-1 && SS) ss_break++;
    end
    set_req(p, 1'b0);
  endtask

  task automatic requester(input bit p, input logic [7:0] d);
    set_req(p, 1'b1);
    set_tx(p, d, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_ready(p, 200);
      @(negedge clk_26);
      set_tx(p, d, 1'b1, 1'b0);
      wait_rx(p);
      chk($sformatf("rr_rx_data_p%0d", p), rx_data, d);
      if (k == 0) set_tx(p, d, 1'b1, 1'b1);
    end
    set_req(p, 1'b0);
  endtask

  typedef struct {
    bit         port;
    bit         loopback;
    bit         tie;
    logic [7:0] data;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];
  int   exp_order[4] = '{0, 1, 0, 1};

  initial begin
    int r0, p0, p1, acc;
    vecs[0] = '{port: 1'b0, loopback: 1'b1, tie: 1'b0, data: 8'hA5, exp_rx: 8'hA5};
    vecs[1] = '{port: 1'b1, loopback: 1'b1, tie: 1'b0, data: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{port: 1'b0, loopback: 1'b0, tie: 1'b1, data: 8'h00, exp_rx: 8'hFF};
    vecs[3] = '{port: 1'b1, loopback: 1'b0, tie: 1'b0, data: 8'hFF, exp_rx: 8'h00};
    vecs[4] = '{port: 1'b0, loopback: 1'b1, tie: 1'b0, data: 8'h80, exp_rx: 8'h80};
    vecs[5] = '{port: 1'b1, loopback: 1'b1, tie: 1'b0, data: 8'h01, exp_rx: 8'h01};

    RESET_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    set_tx(0, 8'h00, 1'b0, 1'b0);
    set_tx(1, 8'h00, 1'b0, 1'b0);
    miso_loop = 1'b1; miso_tie = 1'b0;
    repeat (3) @(negedge clk_26);
    chk("rst_gnt", {gnt_1, gnt_0}, 0);
    chk("rst_tx_ready", {tx_ready_1, tx_ready_0}, 0);
    chk("rst_rx_valid", {rx_valid_1, rx_valid_0}, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_ss", SS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    RESET_n = 1'b1;
    @(negedge clk_26);

    for (int v = 0; v < 6; v++) begin
      miso_loop = vecs[v].loopback;
      miso_tie  = vecs[v].tie;
      r0 = rises; p0 = rv0; p1 = rv1;
      run_txn(vecs[v].port, 1, {16'h0000, vecs[v].data});
      chk($sformatf("vec%0d_rx_data", v), rxd[0], vecs[v].exp_rx);
      chk($sformatf("vec%0d_rx_latency", v), rxv_e[0] - acc_e[0], 16*CD);
      chk($sformatf("vec%0d_release_ss", v), SS, 1);
      chk($sformatf("vec%0d_release_gnt", v), {gnt_1, gnt_0}, 0);
      repeat (2*CD - 1) @(negedge clk_26);
      chk($sformatf("vec%0d_release_busy", v), busy, 1);
      @(negedge clk_26);
      chk($sformatf("vec%0d_idle_busy", v), busy, 0);
      chk($sformatf("vec%0d_sclk_rises", v), rises - r0, 8);
      chk($sformatf("vec%0d_mosi_bits", v), mosi_cap, vecs[v].data);
      chk($sformatf("vec%0d_rx_own", v), vecs[v].port ? rv1 - p1 : rv0 - p0, 1);
      chk($sformatf("vec%0d_rx_other", v), vecs[v].port ? rv0 - p0 : rv1 - p1, 0);
    end

    // Three-byte transaction, MISO tied high, tx_valid held across bytes.
    miso_loop = 1'b0; miso_tie = 1'b1;
    p0 = rv0;
    run_txn(0, 3, {8'h03, 8'h02, 8'h01});
    chk("multi_ss_continuous", ss_break, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("multi_rx%0d", i), rxd[i], 8'hFF);
    chk("multi_period01", acc_e[1] - acc_e[0], 16*CD + 1);
    chk("multi_period12", acc_e[2] - acc_e[1], 16*CD + 1);
    chk("multi_release_ss", SS, 1);
    repeat (2*CD) @(negedge clk_26);
    chk("multi_rx_pulses", rv0 - p0, 3);

    // Round robin with both requesters active from one cycle after reset.
    RESET_n = 1'b0;
    repeat (2) @(negedge clk_26);
    RESET_n = 1'b1;
    gq.delete();
    miso_loop = 1'b1;
    @(negedge clk_26);
    fork
      requester(0, 8'h69);
      requester(1, 8'h96);
    join
    repeat (2*CD + 1) @(negedge clk_26);
    chk("rr_grant_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk($sformatf("rr_order%0d", k), gq[k], exp_order[k]);

    // Port 1 abandons the grant in HOLD without offering a byte.
    r0 = rises; p1 = rv1;
    set_req(1, 1'b1);
    wait_gnt(1);
    @(negedge clk_26);
    set_req(1, 1'b0);
    @(negedge clk_26);
    chk("abort_ss", SS, 1);
    chk("abort_gnt", gnt_1, 0);
    repeat (2*CD + 2) @(negedge clk_26);
    chk("abort_sclk_rises", rises - r0, 0);
    chk("abort_rx_pulses", rv1 - p1, 0);
    chk("abort_busy", busy, 0);

    // req_0 drops during bit 3 of a non-last byte.
    miso_loop = 1'b1;
    p0 = rv0;
    set_req(0, 1'b1);
    wait_gnt(0);
    set_tx(0, 8'h5A, 1'b0, 1'b1);
    wait_ready(0, 20);
    acc = cyc + 1;
    @(negedge clk_26);
    set_tx(0, 8'h00, 1'b0, 1'b0);
    repeat (8*CD + 1) @(negedge clk_26);
    set_req(0, 1'b0);
    wait_rx(0);
    chk("drop_latency", cyc - acc, 16*CD);
    chk("drop_rx_data", rx_data, 8'h5A);
    chk("drop_release_ss", SS, 1);
    chk("drop_release_gnt", gnt_0, 0);
    chk("drop_tx_ready", tx_ready_0, 0);
    repeat (2*CD) @(negedge clk_26);
    chk("drop_rx_pulses", rv0 - p0, 1);
    chk("drop_busy", busy, 0);

    // Asynchronous reset while SCLK is high mid-byte.
    set_req(0, 1'b1);
    wait_gnt(0);
    set_tx(0, 8'hFF, 1'b1, 1'b1);
    wait_ready(0, 20);
    @(negedge clk_26);
    set_tx(0, 8'h00, 1'b0, 1'b0);
    repeat (10) @(negedge clk_26);
    phase_en = 1'b0;
    p0 = rv0;
    @(negedge clk_26);
    RESET_n = 1'b0;
    #1;
    chk("arst_ss", SS, 1);
    chk("arst_sclk", SCLK, 0);
    chk("arst_mosi", MOSI, 0);
    chk("arst_gnt", gnt_0, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rx_data", rx_data, 8'h00);
    set_req(0, 1'b0);
    repeat (3) @(negedge clk_26);
    RESET_n = 1'b1;
    r0 = rises;
    repeat (40) @(negedge clk_26);
    chk("arst_no_rx", rv0 - p0, 0);
    chk("arst_no_sclk", rises - r0, 0);
    phase_en = 1'b1;
    run_txn(0, 1, {16'h0000, 8'hC3});
    chk("arst_fresh_rx", rxd[0], 8'hC3);
    chk("arst_fresh_latency", rxv_e[0] - acc_e[0], 16*CD);
    repeat (2*CD + 1) @(negedge clk_26);

    chk("never_both_gnt", both_gnt, 0);
    chk("no_cross_ready", xready, 0);
    chk("ss_tracks_gnt", ss_gnt_err, 0);
    chk("sclk_high_phase", phase_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
